// File: rtl/vrf_read_sequencer_pkg.sv
// Shared types and constants for the VRF read sequencer slice.
package vrf_read_sequencer_pkg;

  // Architectural vector registers per lane; each owns MEM_DEPTH/VREG_COUNT rows.
  localparam int VREG_COUNT    = 32;
  localparam int DEF_DEPTH     = 512;
  localparam int ROWS_PER_VREG = DEF_DEPTH / VREG_COUNT;

  typedef logic [4:0]                    vreg_idx_t;
  typedef logic [$clog2(DEF_DEPTH)-1:0]  vrf_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vrf_read_sequencer_if.sv
// Bundle of request, VRF read-port and operand-stream signals of one lane.
interface vrf_read_sequencer_if #(
  parameter int R_PORTS   = 2,
  parameter int MEM_DEPTH = 512,
  parameter int MEM_WIDTH = 32
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = AW + 1;

  logic                                req_valid_i;
  logic                                req_ready_o;
  logic [R_PORTS-1:0][4:0]             req_vs_i;
  logic [R_PORTS-1:0]                  req_en_i;
  logic [LW-1:0]                       req_len_i;
  logic [R_PORTS-1:0][AW-1:0]          raddr_o;
  logic [R_PORTS-1:0]                  ren_o;
  logic [R_PORTS-1:0]                  oreg_en_o;
  logic [R_PORTS-1:0][MEM_WIDTH-1:0]   dout_i;
  logic                                op_valid_o;
  logic                                op_ready_i;
  logic [R_PORTS-1:0][MEM_WIDTH-1:0]   op_data_o;
  logic                                op_last_o;
  logic                                busy_o;

  // The sequencer itself.
  modport master (
    input  req_valid_i, req_vs_i, req_en_i, req_len_i, dout_i, op_ready_i,
    output req_ready_o, raddr_o, ren_o, oreg_en_o, op_valid_o, op_data_o,
    output op_last_o, busy_o
  );

  // Issue logic, VRF and ALU surrounding the sequencer.
  modport slave (
    output req_valid_i, req_vs_i, req_en_i, req_len_i, dout_i, op_ready_i,
    input  req_ready_o, raddr_o, ren_o, oreg_en_o, op_valid_o, op_data_o,
    input  op_last_o, busy_o
  );

endinterface

// File: rtl/vrf_read_sequencer_rd_fifo.sv
// Operand FIFO: registered storage, occupancy count for credit, push+pop when full.
module vrf_rd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage write; entries are data only and need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/vrf_read_sequencer.sv
// Lane VRF read sequencer: row issue, fixed-latency tracking, credit-protected operand FIFO.
module vrf_read_sequencer
  import vrf_read_sequencer_pkg::*;
#(
  parameter int R_PORTS      = 2,
  parameter int MEM_DEPTH    = 512,
  parameter int MEM_WIDTH    = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                 clk,
  input logic                 rstn,
  vrf_read_sequencer_if.master bus
);
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int LW  = AW + 1;
  localparam int RPV = MEM_DEPTH / VREG_COUNT;
  localparam int FW  = R_PORTS * MEM_WIDTH + 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  seq_state_e                          state, state_nxt;
  vreg_idx_t  [R_PORTS-1:0]            vs_q;
  logic       [R_PORTS-1:0]            en_q;
  logic       [LW-1:0]                 len_q;
  logic       [LW-1:0]                 idx_q;
  logic       [CW-1:0]                 inflight_q;
  logic       [READ_LATENCY-1:0]       vld_p;
  logic       [READ_LATENCY-1:0]       last_p;
  logic                                req_ready, accept, issue, issue_last, credit_ok;
  logic                                push, pop, fifo_empty, fifo_last;
  logic       [FCW-1:0]                fifo_count;
  logic       [FW-1:0]                 fifo_rdata;
  logic       [R_PORTS-1:0][MEM_WIDTH-1:0] push_data;

  // Rows issued but not yet captured plus rows parked in the FIFO must fit the FIFO.
  assign credit_ok  = ((inflight_q + CW'(fifo_count)) < DEPTH_C);
  assign accept     = bus.req_valid_i & req_ready;
  assign issue_last = issue & (idx_q == (len_q - 1'b1));
  assign push       = vld_p[READ_LATENCY-1];
  assign pop        = ~fifo_empty & bus.op_ready_i;

  // Request state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, request handshake and row-issue decision.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i && (bus.req_len_i != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue = credit_ok;
        if (issue && (idx_q == (len_q - 1'b1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((inflight_q == '0) &&
            ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request operands are latched once per accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      vs_q  <= bus.req_vs_i;
      en_q  <= bus.req_en_i;
      len_q <= bus.req_len_i;
    end
  end

  // Element index: restarts on accept, advances on each issued row.
  always_ff @(posedge clk) begin
    if (!rstn)       idx_q <= '0;
    else if (accept) idx_q <= '0;
    else if (issue)  idx_q <= idx_q + 1'b1;
  end

  // ---- stage p0..pN: read-latency shift pipe of {issue, last} ----
  // Latency pipe tracks each issued row until its dout is valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p  <= {vld_p[READ_LATENCY-2:0], issue};
      last_p <= {last_p[READ_LATENCY-2:0], issue_last};
    end
  end

  // Outstanding-read counter used for the credit check.
  always_ff @(posedge clk) begin
    if (!rstn) inflight_q <= '0;
    else begin
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Address generation, port enables and capture masking per operand.
  always_comb begin
    logic [31:0] row;
    for (int p = 0; p < R_PORTS; p++) begin
      row              = 32'(vs_q[p]) * 32'(RPV) + 32'(idx_q);
      bus.ren_o[p]     = issue & en_q[p];
      bus.raddr_o[p]   = bus.ren_o[p] ? row[AW-1:0] : '0;
      bus.oreg_en_o[p] = vld_p[READ_LATENCY-2] & en_q[p];
      push_data[p]     = en_q[p] ? bus.dout_i[p] : '0;
    end
  end

  // ---- capture stage: dout into operand FIFO ----
  vrf_rd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({last_p[READ_LATENCY-1], push_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign {fifo_last, bus.op_data_o} = fifo_rdata;
  assign bus.op_valid_o  = ~fifo_empty;
  assign bus.op_last_o   = fifo_last & ~fifo_empty;
  assign bus.req_ready_o = req_ready;
  assign bus.busy_o      = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Directed bench for vrf_read_sequencer with a VRF model and an operand scoreboard.
module tb_vrf_read_sequencer;
  localparam int R_PORTS = 2, MEM_DEPTH = 512, MEM_WIDTH = 32;
  localparam int READ_LATENCY = 2, FIFO_DEPTH = 4;
  localparam int RPV = MEM_DEPTH / 32;

  typedef struct packed {
    logic [1:0][31:0] data;
    logic             last;
  } tuple_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vrf_read_sequencer_if #(.R_PORTS(R_PORTS), .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH)) bus ();

  vrf_read_sequencer #(
    .R_PORTS(R_PORTS), .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH),
    .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input longint act, input longint exp);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // VRF content: a fixed function of port and row
  function automatic logic [31:0] vrf_word(input int p, input int a);
    return 32'h5A00_0000 ^ (32'(p) << 28) ^ (32'(a) * 32'h0001_0003);
  endfunction

  // VRF model: row sampled on ren, output register loaded on oreg_en
  logic [1:0][31:0] vrf_s1  = {2{32'hDEAD_BEEF}};
  logic [1:0][31:0] vrf_out = {2{32'hDEAD_BEEF}};
  assign bus.dout_i = vrf_out;
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (bus.ren_o[p])     vrf_s1[p]  <= vrf_word(p, int'(bus.raddr_o[p]));
      if (bus.oreg_en_o[p]) vrf_out[p] <= vrf_s1[p];
    end
    cyc <= cyc + 1;
  end

  // Consumer ready: fixed level or ~70% random
  bit rnd_mode = 0;
  bit ready_fixed = 1;
  always @(posedge clk) begin
    #1;
    bus.op_ready_i = rnd_mode ? ($urandom_range(0, 99) < 70) : ready_fixed;
  end

  // Scoreboard / request model
  tuple_t      exp_q[$];
  int          cur_vs[2];
  logic [1:0]  cur_en = 2'b00;
  int          cur_len = 0, issue_idx = 0, hs_req = 0, stall_cycles = 0;
  int          addr_log0[$], addr_log1[$];
  int          first_hs_cyc = 0, last_hs_cyc = 0;
  logic [1:0][31:0] first_data = '0;
  bit          ren1_seen = 0, oreg1_seen = 0;
  bit          chk_on = 0;

  function automatic int exp_addr(input int p, input int i);
    return (cur_vs[p] * RPV + i) % MEM_DEPTH;
  endfunction

  function automatic void load_model(input int vs0, input int vs1, input logic [1:0] en, input int len);
    tuple_t t;
    cur_vs[0] = vs0; cur_vs[1] = vs1; cur_en = en; cur_len = len;
    issue_idx = 0; hs_req = 0; stall_cycles = 0;
    ren1_seen = 0; oreg1_seen = 0;
    exp_q.delete(); addr_log0.delete(); addr_log1.delete();
    for (int i = 0; i < len; i++) begin
      for (int p = 0; p < 2; p++)
        t.data[p] = en[p] ? vrf_word(p, exp_addr(p, i)) : 32'h0;
      t.last = (i == len - 1);
      exp_q.push_back(t);
    end
  endfunction

  // Per-cycle compare of VRF port activity and operand stream against the model
  logic [1:0]       ren_prev = 2'b00;
  bit               prev_hold = 0;
  logic [1:0][31:0] prev_data = '0;
  logic             prev_last = 1'b0;
  always @(negedge clk) begin
    if (rstn && chk_on) begin
      tuple_t t;
      check("oreg_en_timing", bus.oreg_en_o, ren_prev);
      check("ren_unused_port", bus.ren_o & ~cur_en, 0);
      if (bus.ren_o[1]) ren1_seen = 1;
      if (bus.oreg_en_o[1]) oreg1_seen = 1;
      if (bus.ren_o != 2'b00) begin
        check("ren_mask", bus.ren_o, cur_en);
        if (issue_idx >= cur_len) fail_now("ren_beyond_len", issue_idx, cur_len);
        else begin
          check("credit_limit", ((issue_idx - hs_req) < FIFO_DEPTH), 1);
          if (cur_en[0]) check("raddr_p0", bus.raddr_o[0], exp_addr(0, issue_idx));
          if (cur_en[1]) check("raddr_p1", bus.raddr_o[1], exp_addr(1, issue_idx));
          addr_log0.push_back(int'(bus.raddr_o[0]));
          addr_log1.push_back(int'(bus.raddr_o[1]));
          issue_idx++;
        end
      end else if (issue_idx > 0 && issue_idx < cur_len) stall_cycles++;
      ren_prev = bus.ren_o;
      if (prev_hold) begin
        check("hold_valid", bus.op_valid_o, 1);
        check("hold_data", bus.op_data_o, prev_data);
        check("hold_last", bus.op_last_o, prev_last);
      end
      if (bus.op_valid_o && bus.op_ready_i) begin
        if (exp_q.size() == 0) fail_now("tuple_extra", bus.op_data_o, 0);
        else begin
          t = exp_q.pop_front();
          check("op_data", bus.op_data_o, t.data);
          check("op_last", bus.op_last_o, t.last);
          hs_req++;
          if (hs_req == 1) begin first_hs_cyc = cyc; first_data = bus.op_data_o; end
          last_hs_cyc = cyc;
        end
      end
      prev_hold = bus.op_valid_o && !bus.op_ready_i;
      prev_data = bus.op_data_o;
      prev_last = bus.op_last_o;
    end else begin
      ren_prev  = 2'b00;
      prev_hold = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int vs0, input int vs1, input logic [1:0] en,
                           input int len, output int waited);
    bus.req_valid_i = 1'b1;
    bus.req_vs_i    = {5'(vs1), 5'(vs0)};
    bus.req_en_i    = en;
    bus.req_len_i   = 10'(len);
    waited = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        @(posedge clk);
        load_model(vs0, vs1, en, len);
        waited = k;
        break;
      end
    end
    #1;
    bus.req_valid_i = 1'b0;
    if (waited < 0) fail_now("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      if (exp_q.size() == 0 && issue_idx >= cur_len && !bus.busy_o) done = 1;
      else tick();
    end
    if (!done) fail_now("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready_o, 1);
    check({tag, "_ren"}, bus.ren_o, 0);
    check({tag, "_oreg_en"}, bus.oreg_en_o, 0);
    check({tag, "_op_valid"}, bus.op_valid_o, 0);
    check({tag, "_op_last"}, bus.op_last_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_raddr"}, bus.raddr_o, 0);
  endtask

  initial begin
    int w;
    bus.req_valid_i = 1'b0;
    bus.req_vs_i    = '0;
    bus.req_en_i    = '0;
    bus.req_len_i   = '0;
    rstn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    chk_on = 1;
    tick();

    // T1: vs={2,5}, both ports, len 16, full throughput
    ready_fixed = 1;
    start_req(2, 5, 2'b11, 16, w);
    tick(); check("t1_lat_c1", bus.op_valid_o, 0);
    tick(); check("t1_lat_c2", bus.op_valid_o, 0);
    tick(); check("t1_lat_c3", bus.op_valid_o, 1);
    wait_done(200);
    check("t1_tuples", hs_req, 16);
    check("t1_p0_first", addr_log0[0], 32);
    check("t1_p0_last", addr_log0[15], 47);
    check("t1_p1_first", addr_log1[0], 80);
    check("t1_p1_last", addr_log1[15], 95);
    check("t1_back_to_back", last_hs_cyc - first_hs_cyc, 15);
    check("t1_data_p0", first_data[0], 32'h5A20_0060);
    check("t1_data_p1", first_data[1], 32'h4A50_00F0);
    check("t1_ready_after", bus.req_ready_o, 1);

    // T2: wrap at the top of the VRF
    start_req(31, 0, 2'b11, 20, w);
    wait_done(200);
    check("t2_tuples", hs_req, 20);
    check("t2_p0_row15", addr_log0[15], 511);
    check("t2_p0_row16", addr_log0[16], 0);
    check("t2_p0_row19", addr_log0[19], 3);
    check("t2_p1_row19", addr_log1[19], 19);

    // T3: random backpressure, len 64
    rnd_mode = 1;
    start_req(3, 7, 2'b11, 64, w);
    wait_done(2000);
    rnd_mode = 0;
    tick();
    check("t3_tuples", hs_req, 64);
    check("t3_issue_stalled", (stall_cycles > 0), 1);

    // T4: only port 0 enabled
    start_req(4, 9, 2'b01, 4, w);
    wait_done(200);
    check("t4_tuples", hs_req, 4);
    check("t4_ren1_seen", ren1_seen, 0);
    check("t4_oreg1_seen", oreg1_seen, 0);
    check("t4_data_p0", first_data[0], 32'h5A40_00C0);
    check("t4_data_p1", first_data[1], 0);

    // T5: zero-length request
    start_req(1, 1, 2'b11, 0, w);
    check("t5_accept_wait", w, 0);
    for (int k = 0; k < 6; k++) begin
      check("t5_busy", bus.busy_o, 0);
      check("t5_op_valid", bus.op_valid_o, 0);
      check("t5_ren", bus.ren_o, 0);
      tick();
    end
    check("t5_ready", bus.req_ready_o, 1);

    // T6: reset in the middle of a len-32 request, then a clean request
    start_req(6, 10, 2'b11, 32, w);
    w = 0;
    for (int k = 0; k < 100 && hs_req < 7; k++) begin tick(); w = k; end
    if (hs_req < 7) fail_now("t6_reach_elem7_timeout", hs_req, 7);
    rstn = 1'b0;
    exp_q.delete();
    cur_len = 0; issue_idx = 0; hs_req = 0;
    tick();
    rstn = 1'b1;
    check_reset_outputs("t6_midreset");
    tick();
    check("t6_fifo_empty", bus.op_valid_o, 0);
    start_req(8, 12, 2'b11, 8, w);
    wait_done(200);
    check("t6_new_tuples", hs_req, 8);
    check("t6_new_p0_first", addr_log0[0], 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
